// File: rtl/systolic_array_pkg.sv
// Shared definitions for the output-stationary systolic matmul array.
package systolic_array_pkg;

   localparam int unsigned DEF_N     = 2;
   localparam int unsigned DEF_WIDTH = 32;

   // Operand / accumulator word at the default width.
   typedef logic [DEF_WIDTH-1:0] word_t;

endpackage : systolic_array_pkg

// File: rtl/systolic_pe.sv
// One processing element: forwards its operands one hop and accumulates their product.
module systolic_pe
   import systolic_array_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] acc
);

   logic [WIDTH-1:0] prod_c;

   // Product kept at WIDTH bits: the high half is intentionally dropped.
   always_comb begin
      prod_c = a_in * b_in;
   end

   // Operand pipeline and accumulator; reset wins over enable, en low freezes everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else if (en) begin
         a_out <= a_in;
         b_out <= b_in;
         acc   <= acc + prod_c;
      end
   end

endmodule : systolic_pe

// File: rtl/systolic_array.sv
// N x N output-stationary systolic array; A enters on the left, B on the top, pre-skewed.
module systolic_array
   import systolic_array_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             en,
   input  logic [N-1:0][WIDTH-1:0]          A,
   input  logic [N-1:0][WIDTH-1:0]          B,
   output logic [N-1:0][N-1:0][WIDTH-1:0]   Out
);

   // a_link[i][j] / b_link[i][j] are the operand registers of PE(i,j).
   logic [WIDTH-1:0] a_link [N][N];
   logic [WIDTH-1:0] b_link [N][N];
   logic [WIDTH-1:0] acc_q  [N][N];

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [WIDTH-1:0] a_src;
         logic [WIDTH-1:0] b_src;

         // Edge PEs take the external operand, interior PEs take their neighbour's register.
         if (j == 0) begin : g_a_edge
            assign a_src = A[i];
         end else begin : g_a_int
            assign a_src = a_link[i][j-1];
         end

         if (i == 0) begin : g_b_edge
            assign b_src = B[j];
         end else begin : g_b_int
            assign b_src = b_link[i-1][j];
         end

         systolic_pe #(
            .WIDTH (WIDTH)
         ) u_pe (
            .clock (clock),
            .reset (reset),
            .en    (en),
            .a_in  (a_src),
            .b_in  (b_src),
            .a_out (a_link[i][j]),
            .b_out (b_link[i][j]),
            .acc   (acc_q[i][j])
         );

         assign Out[i][j] = acc_q[i][j];
      end
   end

endmodule : systolic_array

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array (N=2, WIDTH=32): directed table plus random matmuls.
module tb_systolic_array;
   import systolic_array_pkg::*;

   localparam int unsigned N    = 2;
   localparam int unsigned W    = 32;
   localparam int          KMAX = 3;

   typedef logic [W-1:0] mat_a_t [N][KMAX];   // am[i][k] = row i, element k
   typedef logic [W-1:0] mat_b_t [KMAX][N];   // bm[k][j] = column j, element k
   typedef logic [W-1:0] mat_o_t [N][N];

   typedef struct {
      string  name;
      mat_a_t am;
      mat_b_t bm;
      int     k;
      mat_o_t exp;
   } vec_t;

   logic                      clock = 1'b0;
   logic                      reset;
   logic                      en;
   logic [N-1:0][W-1:0]       A;
   logic [N-1:0][W-1:0]       B;
   logic [N-1:0][N-1:0][W-1:0] Out;

   int n_cmp  = 0;
   int n_fail = 0;

   systolic_array #(.N(N), .WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .A     (A),
      .B     (B),
      .Out   (Out)
   );

   always #5 clock = ~clock;

   // Reference: C[i][j] = sum over k of a_i[k]*b_j[k] mod 2^W, counting only the
   // terms whose meeting edge k+i+j has already happened.
   function automatic logic [W-1:0] model_acc(mat_a_t am, mat_b_t bm, int k,
                                              int last_edge, int i, int j);
      logic [W-1:0] s;
      logic [W-1:0] p;
      s = '0;
      for (int kk = 0; kk < k; kk++) begin
         if (kk + i + j <= last_edge) begin
            p = am[i][kk] * bm[kk][j];
            s = s + p;
         end
      end
      return s;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, got, got, exp, exp);
      end
   endtask

   task automatic chk_all(input string tag, input mat_o_t exp);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            chk($sformatf("%s Out[%0d][%0d]", tag, i, j), Out[i][j], exp[i][j]);
   endtask

   task automatic chk_zero(input string tag);
      mat_o_t z;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            z[i][j] = '0;
      chk_all(tag, z);
   endtask

   task automatic chk_model(input string tag, input mat_a_t am, input mat_b_t bm,
                            input int k, input int last_edge);
      mat_o_t e;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            e[i][j] = model_acc(am, bm, k, last_edge, i, j);
      chk_all(tag, e);
   endtask

   // One reset edge with nonzero operands and en high; nothing may accumulate.
   task automatic do_reset();
      reset = 1'b1;
      en    = 1'b1;
      A     = {W'(32'h1234_5678), W'(32'h0000_0007)};
      B     = {W'(32'h0000_0009), W'(32'h8765_4321)};
      @(negedge clock);
      reset = 1'b0;
      A     = '0;
      B     = '0;
   endtask

   // Drive n_edges skewed operand edges; optional 2-cycle stall (feeder frozen) after edge stall_after.
   task automatic feed(input string tag, input mat_a_t am, input mat_b_t bm, input int k,
                       input int n_edges, input int stall_after);
      for (int e = 0; e < n_edges; e++) begin
         en = 1'b1;
         for (int i = 0; i < N; i++)
            A[i] = (e - i >= 0 && e - i < k) ? am[i][e-i] : '0;
         for (int j = 0; j < N; j++)
            B[j] = (e - j >= 0 && e - j < k) ? bm[e-j][j] : '0;
         @(negedge clock);
         if (e == stall_after) begin
            for (int s = 0; s < 2; s++) begin
               en = 1'b0;
               A  = {W'($urandom), W'($urandom)};
               B  = {W'($urandom), W'($urandom)};
               @(negedge clock);
               chk_model($sformatf("%s stall%0d", tag, s), am, bm, k, e);
            end
            en = 1'b1;
         end
      end
      A = '0;
      B = '0;
   endtask

   vec_t   tbl[3];
   mat_a_t basic_a;
   mat_b_t basic_b;

   initial begin
      reset = 1'b0;
      en    = 1'b0;
      A     = '0;
      B     = '0;

      // Directed vectors with hand-derived results.
      basic_a = '{'{32'd3, 32'd6, 32'd0}, '{32'd4, 32'd5, 32'd0}};
      basic_b = '{'{32'd2, 32'd1}, '{32'd10, 32'd8}, '{32'd0, 32'd0}};

      tbl[0].name = "basic";
      tbl[0].am   = basic_a;
      tbl[0].bm   = basic_b;
      tbl[0].k    = 2;
      tbl[0].exp  = '{'{32'd66, 32'd51}, '{32'd58, 32'd44}};

      tbl[1].name = "identity";
      tbl[1].am   = '{'{32'd1, 32'd0, 32'd0}, '{32'd0, 32'd1, 32'd0}};
      tbl[1].bm   = '{'{32'd2, 32'd1}, '{32'd10, 32'd8}, '{32'd0, 32'd0}};
      tbl[1].k    = 2;
      tbl[1].exp  = '{'{32'd2, 32'd1}, '{32'd10, 32'd8}};

      tbl[2].name = "wrap";
      tbl[2].am   = '{'{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0}, '{32'd0, 32'd0, 32'd0}};
      tbl[2].bm   = '{'{32'hFFFF_FFFF, 32'd0}, '{32'hFFFF_FFFF, 32'd0}, '{32'd0, 32'd0}};
      tbl[2].k    = 2;
      tbl[2].exp  = '{'{32'd2, 32'd0}, '{32'd0, 32'd0}};

      @(negedge clock);
      do_reset();
      chk_zero("reset");

      // Table-driven directed runs; each final result must also hold over idle edges.
      for (int t = 0; t < 3; t++) begin
         do_reset();
         feed(tbl[t].name, tbl[t].am, tbl[t].bm, tbl[t].k, tbl[t].k + 2, -1);
         chk_all(tbl[t].name, tbl[t].exp);
         repeat (3) @(negedge clock);
         chk_all({tbl[t].name, " hold"}, tbl[t].exp);
      end

      // Stall after the second operand edge with the feeder frozen.
      do_reset();
      feed("stall", basic_a, basic_b, 2, 4, 1);
      chk_all("stall final", tbl[0].exp);

      // Reset after three edges of the basic sequence, then a full restart.
      do_reset();
      feed("abort", basic_a, basic_b, 2, 3, -1);
      chk_model("abort partial", basic_a, basic_b, 2, 2);
      do_reset();
      chk_zero("midreset");
      feed("restart", basic_a, basic_b, 2, 4, -1);
      chk_all("restart", tbl[0].exp);

      // Random matmuls against the arithmetic model, some with a random stall.
      for (int r = 0; r < 8; r++) begin
         mat_a_t ra;
         mat_b_t rb;
         int     rk;
         int     st;
         rk = int'($urandom_range(KMAX, 1));
         for (int i = 0; i < N; i++)
            for (int kk = 0; kk < KMAX; kk++)
               ra[i][kk] = (r % 2 == 0) ? W'($urandom_range(255, 0)) : W'($urandom);
         for (int kk = 0; kk < KMAX; kk++)
            for (int j = 0; j < N; j++)
               rb[kk][j] = (r % 2 == 0) ? W'($urandom_range(255, 0)) : W'($urandom);
         st = (r % 3 == 0) ? int'($urandom_range(rk, 0)) : -1;
         do_reset();
         feed($sformatf("rand%0d", r), ra, rb, rk, rk + 2, st);
         chk_model($sformatf("rand%0d", r), ra, rb, rk, rk + 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_systolic_array
